// File: rtl/cpu.sv
// VeriRISC accumulator CPU: 8-bit datapath, 5-bit address, 32x8 unified memory.
// Latency: every instruction takes 8 clocks (fixed fetch/execute phase sequence).
// Backpressure: none; runs freely from reset release until HLT, then freezes.

package opcodes;
    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;
endpackage

// Unified instruction/data store: 32 x 8, contents not reset.
// Latency: combinational read, write lands on the clock edge.
// Backpressure: none.
module cpu_mem (
    input  logic       clk,
    input  logic       wr,
    input  logic [4:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] memory [0:31];

    assign rdata = memory[addr];

    // Synchronous write; the array is loaded by backdoor so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr) begin
            memory[addr] <= wdata;
        end
    end

endmodule

// Top-level core: phase sequencer, PC, IR, accumulator, ALU and memory.
// Latency: 8 clocks per instruction; halt asserts at the edge ending OP_ADDR of HLT.
// Backpressure: none; once halted all architectural state holds until reset.
module cpu
    import opcodes::*;
(
    input  logic clk,
    input  logic rst,
    output logic halt,
    output logic load_ir
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    phase_t     phase_q, phase_d;
    logic [4:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] acc_q, acc_d;
    logic       halt_q, halt_d;
    logic       load_ir_q, load_ir_d;

    logic       sel, rd, inc_pc, ld_pc, ld_ac, wr, data_e, halt_set;
    logic       run, aluop, zero;
    logic [4:0] pc_out, mux_addr;
    logic [7:0] alu_out, data, mem_rdata;
    opcode_t    opcode;

    assign opcode   = opcode_t'(ir_q[7:5]);
    assign pc_out   = pc_q;
    assign mux_addr = sel ? pc_q : ir_q[4:0];
    assign zero     = (acc_q == 8'h00);
    assign aluop    = (opcode == ADD) || (opcode == AND) ||
                      (opcode == XOR) || (opcode == LDA);
    assign run      = !halt_q;
    assign halt     = halt_q;
    assign load_ir  = load_ir_q;

    cpu_mem memory1 (
        .clk   (clk),
        .wr    (wr && run),
        .addr  (mux_addr),
        .wdata (data),
        .rdata (mem_rdata)
    );

    // Per-phase control decode; IR load strobe comes from the registered load_ir.
    always_comb begin
        sel      = 1'b0;
        rd       = 1'b0;
        inc_pc   = 1'b0;
        ld_pc    = 1'b0;
        ld_ac    = 1'b0;
        wr       = 1'b0;
        data_e   = 1'b0;
        halt_set = 1'b0;
        case (phase_q)
            INST_ADDR: begin
                sel = 1'b1;
            end
            INST_FETCH, INST_LOAD, IDLE: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            OP_ADDR: begin
                inc_pc   = 1'b1;
                halt_set = (opcode == HLT);
            end
            OP_FETCH: begin
                rd = aluop;
            end
            ALU_OP: begin
                rd     = aluop;
                inc_pc = (opcode == SKZ) && zero;
                ld_pc  = (opcode == JMP);
                data_e = (opcode == STO);
            end
            STORE: begin
                rd     = aluop;
                ld_ac  = aluop;
                inc_pc = (opcode == JMP);
                ld_pc  = (opcode == JMP);
                wr     = (opcode == STO);
                data_e = (opcode == STO);
            end
            default: begin
                sel = 1'b0;
            end
        endcase
    end

    // Shared data bus: accumulator drives it on stores, memory on reads, else idle low.
    always_comb begin
        data = 8'h00;
        if (data_e) begin
            data = acc_q;
        end else if (rd) begin
            data = mem_rdata;
        end
    end

    // ALU: 8-bit, carry discarded; non-ALU opcodes pass the accumulator through.
    always_comb begin
        alu_out = acc_q;
        case (opcode)
            ADD:     alu_out = acc_q + data;
            AND:     alu_out = acc_q & data;
            XOR:     alu_out = acc_q ^ data;
            LDA:     alu_out = data;
            default: alu_out = acc_q;
        endcase
    end

    // Next-state: everything advances only while not halted; ld_pc beats inc_pc.
    always_comb begin
        phase_d = phase_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        halt_d  = halt_q | halt_set;
        if (run) begin
            phase_d = phase_t'(phase_q + 3'd1);
            if (ld_pc) begin
                pc_d = ir_q[4:0];
            end else if (inc_pc) begin
                pc_d = pc_q + 5'd1;
            end
            if (load_ir_q) begin
                ir_d = data;
            end
            if (ld_ac) begin
                acc_d = alu_out;
            end
        end
        load_ir_d = (phase_d == INST_LOAD) || (phase_d == IDLE);
    end

    // Phase sequencer and architectural state with registered halt/load_ir outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q   <= INST_ADDR;
            pc_q      <= 5'd0;
            ir_q      <= 8'h00;
            acc_q     <= 8'h00;
            halt_q    <= 1'b0;
            load_ir_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            acc_q     <= acc_d;
            halt_q    <= halt_d;
            load_ir_q <= load_ir_d;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Directed-program bench for the VeriRISC cpu with a halt-event scoreboard.
// Latency: expects halt at edge 8k+5 after reset release for HLT as instruction k.
// Backpressure: none; each program is bounded by a cycle budget.
module tb_cpu;
    import opcodes::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic halt;
    logic load_ir;

    cpu dut (
        .clk     (clk),
        .rst     (rst),
        .halt    (halt),
        .load_ir (load_ir)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string name;
        int    pc;
        int    hedge;
        int    nmem;
        int    maddr [3];
        int    mval  [3];
    } exp_t;

    exp_t sb [$];

    // Rising edges since reset release.
    int edges = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) edges = 0;
        else      edges = edges + 1;
    end

    // Monitor: on each halt event pop the expected record and compare.
    bit   seen    = 1'b0;
    bit   has_cur = 1'b0;
    int   halt_at = 0;
    exp_t cur;
    always @(negedge clk) begin
        if (!rst) begin
            seen = 1'b0;
        end else if (halt && !seen) begin
            seen    = 1'b1;
            halt_at = edges;
            if (sb.size() == 0) begin
                has_cur = 1'b0;
                chk("unexpected_halt", 32'd1, 32'd0);
            end else begin
                cur     = sb.pop_front();
                has_cur = 1'b1;
                chk({cur.name, "_pc"}, 32'(dut.pc_out), cur.pc);
                chk({cur.name, "_halt_edge"}, edges, cur.hedge);
                for (int i = 0; i < cur.nmem; i++) begin
                    chk($sformatf("%s_mem%0h", cur.name, cur.maddr[i]),
                        32'(dut.memory1.memory[cur.maddr[i]]), cur.mval[i]);
                end
            end
        end else if (seen && has_cur && edges == halt_at + 20) begin
            chk({cur.name, "_frozen_pc"}, 32'(dut.pc_out), cur.pc);
            chk({cur.name, "_frozen_halt"}, 32'(halt), 32'd1);
        end
    end

    task automatic clr_mem();
        for (int i = 0; i < 32; i++) dut.memory1.memory[i] = 8'h00;
    endtask

    task automatic poke(input int a, input logic [7:0] v);
        dut.memory1.memory[a] = v;
    endtask

    task automatic expect_halt(input string nm, input int pc, input int k, input int nmem,
                               input int a0, input int v0, input int a1, input int v1,
                               input int a2, input int v2);
        exp_t e;
        e.name  = nm;
        e.pc    = pc;
        e.hedge = 8 * k + 5;
        e.nmem  = nmem;
        e.maddr[0] = a0; e.mval[0] = v0;
        e.maddr[1] = a1; e.mval[1] = v1;
        e.maddr[2] = a2; e.mval[2] = v2;
        sb.push_back(e);
    endtask

    // Wait (bounded) for halt, then long enough for the frozen-state check.
    task automatic wait_halt(input string nm);
        for (int i = 0; i < 300 && !halt; i++) @(negedge clk);
        if (!halt) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
            sb.delete();
        end
        repeat (25) @(negedge clk);
    endtask

    task automatic load_arith();
        clr_mem();
        poke(5'h00, 8'hBA);   // LDA 1A
        poke(5'h01, 8'h5B);   // ADD 1B
        poke(5'h02, 8'hDC);   // STO 1C
        poke(5'h03, 8'h00);   // HLT
        poke(5'h1A, 8'h05);
        poke(5'h1B, 8'h03);
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_pc", 32'(dut.pc_out), 32'd0);
        chk("reset_halt", 32'(halt), 32'd0);
        chk("reset_load_ir", 32'(load_ir), 32'd0);

        // Arithmetic and store
        load_arith();
        expect_halt("arith", 4, 3, 1, 5'h1C, 8'h08, 0, 0, 0, 0);
        rst = 1'b1;
        wait_halt("arith");

        // Reset while halted clears halt and pc immediately
        rst = 1'b0;
        #1;
        chk("rst_halted_halt", 32'(halt), 32'd0);
        chk("rst_halted_pc", 32'(dut.pc_out), 32'd0);

        // Mid-run reset during IDLE of the second instruction
        @(negedge clk);
        poke(5'h1C, 8'h00);
        rst = 1'b1;
        repeat (11) @(negedge clk);
        chk("midrun_load_ir_before", 32'(load_ir), 32'd1);
        chk("midrun_pc_before", 32'(dut.pc_out), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrun_rst_pc", 32'(dut.pc_out), 32'd0);
        chk("midrun_rst_load_ir", 32'(load_ir), 32'd0);
        chk("midrun_rst_halt", 32'(halt), 32'd0);

        // Restart: first fetch from address 00, then complete normally
        @(negedge clk);
        expect_halt("rerun", 4, 3, 1, 5'h1C, 8'h08, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("restart_mux_addr", 32'(dut.mux_addr), 32'd0);
        repeat (3) @(negedge clk);
        chk("restart_opcode", 32'(dut.opcode), 32'(LDA));
        wait_halt("rerun");

        // SKZ with zero accumulator skips the HLT at 02
        rst = 1'b0;
        clr_mem();
        poke(5'h00, 8'hBE);   // LDA 1E
        poke(5'h01, 8'h20);   // SKZ
        poke(5'h1E, 8'h00);
        expect_halt("skz_zero", 4, 2, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        wait_halt("skz_zero");

        // SKZ with nonzero accumulator falls into HLT at 02
        rst = 1'b0;
        poke(5'h1E, 8'h07);
        expect_halt("skz_nonzero", 3, 2, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        wait_halt("skz_nonzero");

        // JMP with PC wraparound
        rst = 1'b0;
        clr_mem();
        poke(5'h00, 8'hFF);   // JMP 1F
        poke(5'h1F, 8'hE5);   // JMP 05
        poke(5'h05, 8'h00);   // HLT
        expect_halt("jmp", 6, 2, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        wait_halt("jmp");

        // Logic ops and carry-dropping add
        rst = 1'b0;
        clr_mem();
        poke(5'h00, 8'hBA);   // LDA 1A  (F0)
        poke(5'h01, 8'h7B);   // AND 1B  (3C) -> 30
        poke(5'h02, 8'hDC);   // STO 1C
        poke(5'h03, 8'h9D);   // XOR 1D  (FF) -> CF
        poke(5'h04, 8'hDE);   // STO 1E
        poke(5'h05, 8'hB9);   // LDA 19  (FF)
        poke(5'h06, 8'h58);   // ADD 18  (02) -> 01
        poke(5'h07, 8'hD7);   // STO 17
        poke(5'h08, 8'h00);   // HLT
        poke(5'h18, 8'h02);
        poke(5'h19, 8'hFF);
        poke(5'h1A, 8'hF0);
        poke(5'h1B, 8'h3C);
        poke(5'h1D, 8'hFF);
        expect_halt("logic", 9, 8, 3, 5'h1C, 8'h30, 5'h1E, 8'hCF, 5'h17, 8'h01);
        @(negedge clk);
        rst = 1'b1;
        wait_halt("logic");

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
